// File: rtl/nonce_sweep_ctrl.sv
// Nonce sweep controller: walks a hash core through an inclusive, wrapping nonce range
// until a hash falls below the target, the range runs out, or the job is aborted.
module nonce_sweep_ctrl #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_end,
    input  logic [HASH_W-1:0]  job_target,
    input  logic               abort,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [1:0]         result_status,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [NONCE_W:0]   result_count,
    output logic               busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [1:0] ST_FOUND     = 2'b00;
    localparam logic [1:0] ST_EXHAUSTED = 2'b01;
    localparam logic [1:0] ST_ABORTED   = 2'b10;

    localparam logic [NONCE_W-1:0] NONCE_ONE = 1;
    localparam logic [NONCE_W:0]   COUNT_ONE = 1;

    logic [2:0]         state_q, state_d;
    logic [NONCE_W-1:0] cur_nonce_q, cur_nonce_d;
    logic [NONCE_W-1:0] last_q, last_d;
    logic [NONCE_W-1:0] res_nonce_q, res_nonce_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [NONCE_W:0]   count_q, count_d;
    logic [1:0]         status_q, status_d;
    logic               abort_q, abort_d;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        cur_nonce_d = cur_nonce_q;
        last_d      = last_q;
        res_nonce_d = res_nonce_q;
        target_d    = target_q;
        hash_d      = hash_q;
        count_d     = count_q;
        status_d    = status_q;
        abort_d     = abort_q;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    cur_nonce_d = job_nonce_start;
                    last_d      = job_nonce_end;
                    target_d    = job_target;
                    count_d     = '0;
                    abort_d     = 1'b0;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (abort) abort_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (abort) abort_d = 1'b1;
                if (core_done) begin
                    hash_d  = core_hash;
                    count_d = count_q + COUNT_ONE;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) abort_d = 1'b1;
                // A hit wins over a pending abort; the hash already in hand is never thrown away.
                if (hash_q < target_q) begin
                    status_d    = ST_FOUND;
                    res_nonce_d = cur_nonce_q;
                    state_d     = S_REPORT;
                end else if (abort_q) begin
                    status_d    = ST_ABORTED;
                    res_nonce_d = cur_nonce_q;
                    state_d     = S_REPORT;
                end else if (cur_nonce_q == last_q) begin
                    status_d    = ST_EXHAUSTED;
                    res_nonce_d = cur_nonce_q;
                    state_d     = S_REPORT;
                end else begin
                    cur_nonce_d = cur_nonce_q + NONCE_ONE;
                    state_d     = S_LAUNCH;
                end
            end
            S_REPORT: begin
                if (result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    // NOTE: all registers, the wide target and hash included, are reset so nothing is X after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            cur_nonce_q <= '0;
            last_q      <= '0;
            res_nonce_q <= '0;
            target_q    <= '0;
            hash_q      <= '0;
            count_q     <= '0;
            status_q    <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_nonce_q <= cur_nonce_d;
            last_q      <= last_d;
            res_nonce_q <= res_nonce_d;
            target_q    <= target_d;
            hash_q      <= hash_d;
            count_q     <= count_d;
            status_q    <= status_d;
            abort_q     <= abort_d;
        end
    end

    // cur_nonce only moves in CHECK, so core_nonce is steady from launch until done.
    assign job_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign core_start    = (state_q == S_LAUNCH);
    assign core_nonce    = cur_nonce_q;
    assign result_valid  = (state_q == S_REPORT);
    assign result_status = status_q;
    assign result_nonce  = res_nonce_q;
    assign result_count  = count_q;

endmodule
